// File: rtl/coherence_bus_arbiter.sv
// coherence_bus_arbiter
// Round-robin owner selection for the shared snoop bus / L2 port. A grant is
// held until the bus controller reports completion or the watchdog expires,
// followed by one bubble cycle before the next arbitration.
module coherence_bus_arbiter #(
  parameter int CPUS          = 4,
  parameter int CPU_ID_LENGTH = $clog2(CPUS),
  parameter int MAX_HOLD      = 64
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic [CPUS-1:0]                   req,
  input  logic                              bus_done,
  output logic                              grant_valid,
  output logic [CPU_ID_LENGTH-1:0]          grant_id,
  output logic [CPUS-1:0]                   grant_onehot,
  output logic                              timeout,
  output logic [$clog2(MAX_HOLD+1)-1:0]     hold_cnt
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_RELEASE
  } arb_state_t;

  arb_state_t                 state;
  arb_state_t                 state_next;

  logic [CPU_ID_LENGTH-1:0]   last_granted;
  logic [CPU_ID_LENGTH-1:0]   last_granted_next;

  logic                       any_req;
  logic [CPU_ID_LENGTH-1:0]   winner;
  logic                       expiry;

  logic                       grant_valid_next;
  logic [CPU_ID_LENGTH-1:0]   grant_id_next;
  logic [CPUS-1:0]            grant_onehot_next;
  logic                       timeout_next;
  logic [HOLD_W-1:0]          hold_cnt_next;

  assign any_req = |req;
  assign expiry  = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Rotating-priority search: first requester after the last owner, wrapping
  always_comb begin
    logic                     found;
    logic [CPU_ID_LENGTH-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 1; i <= CPUS; i++) begin
      idx = CPU_ID_LENGTH'((int'(last_granted) + i) % CPUS);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection: completion or watchdog ends a grant, release lasts one cycle
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:    if (any_req) state_next = ARB_GRANT;
      ARB_GRANT:   if (bus_done || expiry) state_next = ARB_RELEASE;
      ARB_RELEASE: state_next = ARB_IDLE;
      default:     state_next = ARB_IDLE;
    endcase
  end

  // Next values for the registered outputs and the priority pointer
  always_comb begin
    grant_valid_next  = grant_valid;
    grant_id_next     = grant_id;
    grant_onehot_next = grant_onehot;
    timeout_next      = 1'b0;
    hold_cnt_next     = hold_cnt;
    last_granted_next = last_granted;
    case (state)
      ARB_IDLE: begin
        hold_cnt_next = '0;
        if (any_req) begin
          grant_valid_next  = 1'b1;
          grant_id_next     = winner;
          grant_onehot_next = CPUS'(1) << winner;
        end else begin
          grant_valid_next  = 1'b0;
          grant_onehot_next = '0;
        end
      end
      ARB_GRANT: begin
        hold_cnt_next = (hold_cnt == HOLD_W'(MAX_HOLD)) ? hold_cnt : hold_cnt + HOLD_W'(1);
        if (bus_done) begin
          grant_valid_next  = 1'b0;
          grant_onehot_next = '0;
          last_granted_next = grant_id;
        end else if (expiry) begin
          grant_valid_next  = 1'b0;
          grant_onehot_next = '0;
          last_granted_next = grant_id;
          timeout_next      = 1'b1;
        end
      end
      ARB_RELEASE: begin
        grant_valid_next  = 1'b0;
        grant_onehot_next = '0;
        hold_cnt_next     = '0;
      end
      default: begin
        grant_valid_next  = 1'b0;
        grant_onehot_next = '0;
        hold_cnt_next     = '0;
      end
    endcase
  end

  // Output and priority-pointer registers; the first search after reset starts at id 0
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      grant_onehot <= '0;
      timeout      <= 1'b0;
      hold_cnt     <= '0;
      last_granted <= CPU_ID_LENGTH'(CPUS - 1);
    end else begin
      grant_valid  <= grant_valid_next;
      grant_id     <= grant_id_next;
      grant_onehot <= grant_onehot_next;
      timeout      <= timeout_next;
      hold_cnt     <= hold_cnt_next;
      last_granted <= last_granted_next;
    end
  end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// tb_coherence_bus_arbiter
// Directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_coherence_bus_arbiter;

  localparam int CPUS     = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 8;
  localparam int HW       = $clog2(MAX_HOLD + 1);

  logic            CLK = 1'b0;
  logic            nRST;
  logic [CPUS-1:0] req;
  logic            bus_done;
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;
  logic [CPUS-1:0] grant_onehot;
  logic            timeout;
  logic [HW-1:0]   hold_cnt;

  int checks   = 0;
  int failures = 0;

  coherence_bus_arbiter #(
    .CPUS(CPUS),
    .CPU_ID_LENGTH(IDW),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .req(req),
    .bus_done(bus_done),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .grant_onehot(grant_onehot),
    .timeout(timeout),
    .hold_cnt(hold_cnt)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Rotating priority: first requester after the previous owner, wrapping
  function automatic int rr_pick(int last, logic [CPUS-1:0] r);
    for (int i = 1; i <= CPUS; i++) begin
      if (r[(last + i) % CPUS]) return (last + i) % CPUS;
    end
    return -1;
  endfunction

  // Reference model: owner, cycles held, bubble cycles still owed, previous owner
  logic m_valid;
  logic m_timeout;
  int   m_id;
  int   m_hold;
  int   m_last;
  int   m_gap;

  // Model advances one cycle per rising edge using the inputs driven mid-cycle
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_valid   <= 1'b0;
      m_timeout <= 1'b0;
      m_id      <= 0;
      m_hold    <= 0;
      m_last    <= CPUS - 1;
      m_gap     <= 0;
    end else if (m_valid) begin
      if (bus_done || m_hold == MAX_HOLD - 1) begin
        m_last    <= m_id;
        m_valid   <= 1'b0;
        m_timeout <= ~bus_done;
        m_gap     <= 1;
      end else begin
        m_hold <= m_hold + 1;
      end
    end else if (m_gap > 0) begin
      m_gap     <= m_gap - 1;
      m_timeout <= 1'b0;
      m_hold    <= 0;
    end else begin
      m_timeout <= 1'b0;
      m_hold    <= 0;
      if (req != '0) begin
        m_valid <= 1'b1;
        m_id    <= rr_pick(m_last, req);
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      check_output("grant_valid", 32'(grant_valid), 32'(m_valid));
      check_output("grant_id", 32'(grant_id), m_id);
      check_output("grant_onehot", 32'(grant_onehot), m_valid ? (1 << m_id) : 0);
      check_output("timeout", 32'(timeout), 32'(m_timeout));
      if (m_valid || m_gap == 0) check_output("hold_cnt", 32'(hold_cnt), m_hold);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic apply_stimulus(logic [CPUS-1:0] r, logic d);
    req      = r;
    bus_done = d;
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  // Bounded wait for a grant; reports how many cycles were spent waiting
  task automatic wait_grant(output bit ok, output int waited);
    ok     = 1'b0;
    waited = 0;
    for (int k = 0; k < 20; k++) begin
      if (grant_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
      waited++;
    end
    check_output("grant_arrives", 32'(ok), 1);
  endtask

  // Wait for a grant, confirm its owner, hold it hold_len cycles, then complete it
  task automatic run_grant(int exp_id, int hold_len, bit check_gap);
    bit ok;
    int waited;
    wait_grant(ok, waited);
    if (!ok) return;
    check_output("rr_grant_id", 32'(grant_id), exp_id);
    if (check_gap) check_output("grant_spacing", waited, 2);
    repeat (hold_len - 1) tick();
    bus_done = 1'b1;
    tick();
    bus_done = 1'b0;
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    bit ok;
    int waited;
    int held;
    int rr_exp[5] = '{0, 1, 2, 3, 0};

    nRST = 1'b0;
    apply_stimulus('0, 1'b0);
    repeat (2) @(posedge CLK);
    #2;
    check_output("reset_valid", 32'(grant_valid), 0);
    check_output("reset_id", 32'(grant_id), 0);
    check_output("reset_onehot", 32'(grant_onehot), 0);
    check_output("reset_timeout", 32'(timeout), 0);
    check_output("reset_hold", 32'(hold_cnt), 0);
    nRST = 1'b1;

    repeat (10) begin
      tick();
      check_output("idle_valid", 32'(grant_valid), 0);
      check_output("idle_onehot", 32'(grant_onehot), 0);
    end

    apply_stimulus(4'b0100, 1'b0);
    tick();
    check_output("single_valid", 32'(grant_valid), 1);
    check_output("single_id", 32'(grant_id), 2);
    check_output("single_onehot", 32'(grant_onehot), 32'h4);
    repeat (4) tick();
    check_output("single_hold", 32'(hold_cnt), 4);
    check_output("single_still_valid", 32'(grant_valid), 1);
    apply_stimulus(4'b0000, 1'b1);
    tick();
    bus_done = 1'b0;
    check_output("single_drop_valid", 32'(grant_valid), 0);
    check_output("single_drop_onehot", 32'(grant_onehot), 0);
    check_output("single_id_kept", 32'(grant_id), 2);
    tick();
    check_output("single_idle_valid", 32'(grant_valid), 0);

    pulse_reset();
    apply_stimulus(4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) run_grant(rr_exp[k], 2, k > 0);

    apply_stimulus(4'b1000, 1'b0);
    run_grant(3, 2, 1'b0);
    apply_stimulus(4'b1001, 1'b0);
    run_grant(0, 2, 1'b0);
    run_grant(3, 2, 1'b0);

    apply_stimulus(4'b0010, 1'b0);
    wait_grant(ok, waited);
    check_output("wd_id", 32'(grant_id), 1);
    held = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!grant_valid) break;
      held++;
    end
    check_output("wd_held", held, 8);
    check_output("wd_timeout", 32'(timeout), 1);
    check_output("wd_valid", 32'(grant_valid), 0);
    tick();
    check_output("wd_timeout_pulse", 32'(timeout), 0);

    wait_grant(ok, waited);
    check_output("wd2_id", 32'(grant_id), 1);
    repeat (7) tick();
    check_output("wd2_hold", 32'(hold_cnt), 7);
    bus_done = 1'b1;
    tick();
    bus_done = 1'b0;
    check_output("wd2_no_timeout", 32'(timeout), 0);
    check_output("wd2_valid", 32'(grant_valid), 0);

    apply_stimulus(4'b0100, 1'b0);
    wait_grant(ok, waited);
    check_output("midrst_id", 32'(grant_id), 2);
    repeat (3) tick();
    nRST = 1'b0;
    #1;
    check_output("midrst_valid", 32'(grant_valid), 0);
    check_output("midrst_onehot", 32'(grant_onehot), 0);
    check_output("midrst_gid", 32'(grant_id), 0);
    check_output("midrst_hold", 32'(hold_cnt), 0);
    apply_stimulus(4'b0110, 1'b0);
    tick();
    nRST = 1'b1;
    wait_grant(ok, waited);
    check_output("midrst_first_id", 32'(grant_id), 1);
    bus_done = 1'b1;
    tick();
    bus_done = 1'b0;
    tick();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      if (grant_valid) bus_done = ($urandom_range(0, 5) == 0);
      else             bus_done = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) pulse_reset();
      tick();
    end

    apply_stimulus('0, 1'b0);
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coherence_bus_arbiter.md
Name: coherence_bus_arbiter

Overview:
Round-robin arbiter in front of the coherence bus controller. It selects which of the CPUS L1 requesters (I and D caches of every hart) owns the shared snoop bus and L2 port for one transaction. It holds the grant until the bus controller signals completion, then rotates priority. A watchdog forcibly releases a grant whose transaction never completes.

Parameters:
CPUS, 4, number of L1 requesters (NUM_HARTS*2)
CPU_ID_LENGTH, $clog2(CPUS), width of requester id
MAX_HOLD, 64, max cycles a grant may be held before watchdog release (>=2)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
req  input  CPUS  per-requester bus request (dREN|dWEN of each L1)
bus_done  input  1  1-cycle pulse from bus controller: granted transaction finished
grant_valid  output  1  a requester currently owns the bus
grant_id  output  CPU_ID_LENGTH  id of owning requester
grant_onehot  output  CPUS  one-hot of grant_id, all-zero when grant_valid=0
timeout  output  1  1-cycle pulse: watchdog released a grant
hold_cnt  output  $clog2(MAX_HOLD+1)  cycles current grant has been held (debug)

Behaviour:
- Reset (nRST=0, async): state=ARB_IDLE; grant_valid=0, grant_id=0, grant_onehot=0, timeout=0, hold_cnt=0; last_granted=CPUS-1, so the first search starts at id 0.
- All outputs are registered; no combinational path from req or bus_done to any output.
- States: ARB_IDLE, ARB_GRANT, ARB_RELEASE.
- ARB_IDLE:
  - If req != 0, pick the first set bit scanning ids last_granted+1, +2, ... modulo CPUS (wrap-around).
  - Next cycle: grant_valid=1, grant_id=winner, grant_onehot=1<<winner, hold_cnt=0, state=ARB_GRANT.
  - Latency from req rising to grant_valid is exactly 1 cycle.
  - bus_done in ARB_IDLE is ignored.
- ARB_GRANT:
  - grant_id and grant_onehot are held stable. Changes on req, including the owner dropping its req, are ignored; bus_done is authoritative.
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - If bus_done=1: last_granted=grant_id; next cycle grant_valid=0, grant_onehot=0, state=ARB_RELEASE.
  - Else if hold_cnt==MAX_HOLD-1: last_granted=grant_id; next cycle grant_valid=0, timeout=1 for exactly one cycle, state=ARB_RELEASE.
  - bus_done in the same cycle as watchdog expiry: bus_done wins and timeout stays 0.
- ARB_RELEASE:
  - One bubble cycle with grant_valid=0 so the finished requester can deassert req. No arbitration occurs this cycle.
  - Next state is ARB_IDLE; hold_cnt clears to 0.
- Back-to-back requests: minimum grant-to-grant spacing is 3 cycles (done, release, idle/arbitrate).
- Fairness: a requester holding req continuously is granted after at most CPUS-1 other grants.
- grant_id keeps its last value while grant_valid=0 (not cleared). grant_onehot is always zero when grant_valid=0.
- Mid-operation reset: immediate async return to reset values; any in-flight grant is dropped and priority restarts at id 0.

Test Plan:
- Reset, then req=4'b0000 for 10 cycles -> grant_valid stays 0, timeout 0, grant_onehot 0.
- req=4'b0100, bus_done pulsed 5 cycles after grant -> grant_valid=1, grant_id=2, onehot=4'b0100 one cycle after req. Grant is held 5 cycles, drops the cycle after bus_done, then 1 release cycle follows.
- req=4'b1111 held, bus_done pulsed 2 cycles into each grant -> grant_id sequence 0,1,2,3,0; grant_valid low for 2 cycles between grants.
- After a grant to id 3, req=4'b1001 -> next grant is id 0 (wrap-around); the following grant with req unchanged is id 3.
- MAX_HOLD=8, req=4'b0010, no bus_done -> grant_id=1 held 8 cycles, then timeout=1 for one cycle with grant_valid=0. Repeat with bus_done on the expiry cycle -> timeout stays 0.
- nRST asserted 3 cycles into a grant to id 2 -> outputs zero immediately. After release with req=4'b0110, the first grant is id 1.
